// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
//   Bit-serial adder/subtractor controller. A single full-adder cell is
//   time-shared across the operand width. It processes one bit per clock,
//   LSB first. Subtraction is done as A + ~B + 1: the carry is preloaded
//   with SUB and B is inverted bit by bit.
//
//   Modules in this file:
//     fa_bh           - one-bit behavioural full adder
//     serial_add_ctrl - IDLE/RUN/DONE sequencer plus the serial datapath
//
//   serial_add_ctrl ports:
//     clk    in   1      clock; all state updates on the rising edge
//     clr    in   1      asynchronous active-high reset
//     start  in   1      operation request; sampled only in IDLE
//     sub    in   1      0 = a+b, 1 = a-b; captured with start
//     a, b   in   WIDTH  operands; captured with start
//     sum    out  WIDTH  result of the last completed operation
//     cout   out  1      carry out of the MSB (for sub, 1 = no borrow)
//     ovf    out  1      two's-complement overflow of the last operation
//     busy   out  1      high while in RUN
//     done   out  1      one-cycle pulse; sum/cout/ovf are valid
//
//   State table:
//     state  | meaning
//     IDLE   | waiting for start; result registers hold their values
//     RUN    | one operand bit per clock through the shared full adder
//     DONE   | single-cycle result strobe, then back to IDLE
// -----------------------------------------------------------------------------

module fa_bh (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  // Holds the result bits produced so far. The final bit comes straight
  // from the adder at the last edge, so WIDTH-1 bits of storage are enough.
  logic [WIDTH-2:0] sum_sh;
  logic [WIDTH-2:0] sum_sh_nx;
  logic             carry_ff;
  logic             sub_lat;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic             fa_s;
  logic             fa_co;
  logic             capture;
  logic             step;
  logic             last_bit;
  logic             busy_c;
  logic             done_c;

  // The single shared arithmetic cell.
  fa_bh u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0] ^ sub_lat),
    .ci (carry_ff),
    .s  (fa_s),
    .co (fa_co)
  );

  assign capture  = (state == S_IDLE) && start;
  assign step     = (state == S_RUN);
  assign last_bit = step && (cnt == LAST);

  generate
    if (WIDTH == 2) begin : g_sh_narrow
      assign sum_sh_nx = fa_s;
    end else begin : g_sh_wide
      assign sum_sh_nx = {fa_s, sum_sh[WIDTH-2:1]};
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == LAST) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_c = 1'b0;
    done_c = 1'b0;
    case (state)
      S_RUN:   busy_c = 1'b1;
      S_DONE:  done_c = 1'b1;
      default: begin
        busy_c = 1'b0;
        done_c = 1'b0;
      end
    endcase
  end

  assign busy = busy_c;
  assign done = done_c;

  // ---------------------------------------------------------------------------
  // Serial datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      a_reg    <= '0;
      b_reg    <= '0;
      sum_sh   <= '0;
      carry_ff <= 1'b0;
      sub_lat  <= 1'b0;
      cnt      <= '0;
    end else if (capture) begin
      a_reg    <= a;
      b_reg    <= b;
      sub_lat  <= sub;
      // A carry-in of 1 supplies the +1 of the two's-complement negate.
      carry_ff <= sub;
      cnt      <= '0;
    end else if (step) begin
      a_reg    <= {1'b0, a_reg[WIDTH-1:1]};
      b_reg    <= {1'b0, b_reg[WIDTH-1:1]};
      sum_sh   <= sum_sh_nx;
      carry_ff <= fa_co;
      cnt      <= cnt + CW'(1);
    end
  end

  // Result registers only change at the final bit, so partial sums never
  // appear on the outputs. They hold their values through IDLE and RUN.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_bit) begin
      sum_q  <= {fa_s, sum_sh};
      cout_q <= fa_co;
      // Signed overflow: the carry into the MSB differs from the carry out.
      ovf_q  <= carry_ff ^ fa_co;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clr;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    string        nm;
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_pushed = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input string nm, input logic [W-1:0] s, input logic c,
                      input logic v, input int ecyc);
    exp_t e;
    e.nm  = nm;
    e.s   = s;
    e.c   = c;
    e.v   = v;
    e.cyc = ecyc;
    sb.push_back(e);
    n_pushed++;
  endtask

  // Monitor: one sample per cycle, #1 after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        n_done++;
        if (sb.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_sum"},  {{(32-W){1'b0}}, sum}, {{(32-W){1'b0}}, e.s});
          chk({e.nm, "_cout"}, {31'd0, cout}, {31'd0, e.c});
          chk({e.nm, "_ovf"},  {31'd0, ovf},  {31'd0, e.v});
          chk({e.nm, "_cyc"},  cyc, e.cyc);
        end
      end
    end
  end

  // Waits (bounded) for a DONE pulse, returning on the falling edge where it is seen.
  task automatic wait_done(input string nm);
    bit got = 1'b0;
    for (int i = 0; i < W + 6; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    chk({nm, "_done_seen"}, {31'd0, got}, 32'd1);
  endtask

  // Issue one operation, scramble the inputs after capture, wait for DONE.
  task automatic run_op(input string nm, input logic s_in, input logic [W-1:0] aa,
                        input logic [W-1:0] bb, input logic [W-1:0] es,
                        input logic ec, input logic ev);
    @(negedge clk);
    sub   = s_in;
    a     = aa;
    b     = bb;
    start = 1'b1;
    push(nm, es, ec, ev, cyc + 1 + W);
    @(negedge clk);
    start = 1'b0;
    sub   = ~s_in;
    a     = ~aa;
    b     = aa ^ bb;
    chk({nm, "_busy"}, {31'd0, busy}, 32'd1);
    wait_done(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    clr   = 1'b0;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    #2 clr = 1'b1;
    #1;
    chk("rst_sum",  {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_ovf",  {31'd0, ovf},  32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b0;

    run_op("add_2d_1a", 1'b0, 8'h2D, 8'h1A, 8'h47, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("hold_sum", {24'd0, sum}, 32'h47);

    run_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);
    run_op("add_80_80", 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
    run_op("sub_00_00", 1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    run_op("add_64_64", 1'b0, 8'h64, 8'h64, 8'hC8, 1'b0, 1'b1);
    run_op("add_c0_c0", 1'b0, 8'hC0, 8'hC0, 8'h80, 1'b1, 1'b0);
    run_op("sub_7f_ff", 1'b1, 8'h7F, 8'hFF, 8'h80, 1'b0, 1'b1);

    // START during RUN is ignored; outputs keep the previous result meanwhile.
    @(negedge clk);
    sub   = 1'b0;
    a     = 8'h2D;
    b     = 8'h1A;
    start = 1'b1;
    push("restart", 8'h47, 1'b0, 1'b0, cyc + 1 + W);
    @(negedge clk);
    start = 1'b0;
    a     = 8'h11;
    b     = 8'h22;
    repeat (2) @(negedge clk);
    start = 1'b1;
    sub   = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    chk("midrun_sum_hold", {24'd0, sum}, 32'h80);
    chk("midrun_ovf_hold", {31'd0, ovf}, 32'd1);
    wait_done("restart");
    repeat (W + 4) @(negedge clk);

    // CLR between edges mid-RUN aborts the operation.
    start = 1'b1;
    sub   = 1'b0;
    a     = 8'h7F;
    b     = 8'h01;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    #1;
    chk("abort_sum",  {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    chk("abort_ovf",  {31'd0, ovf},  32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    clr   = 1'b0;
    start = 1'b1;
    sub   = 1'b1;
    a     = 8'h05;
    b     = 8'h07;
    push("post_clr", 8'hFE, 1'b0, 1'b0, cyc + 1 + W);
    @(negedge clk);
    start = 1'b0;
    wait_done("post_clr");

    // START held high: DONE pulses every W+2 cycles.
    @(negedge clk);
    sub   = 1'b0;
    a     = 8'hFF;
    b     = 8'h01;
    start = 1'b1;
    base  = cyc + 1;
    for (int i = 0; i < 3; i++) begin
      push("b2b", 8'h00, 1'b1, 1'b0, base + W + i * (W + 2));
    end
    wait_done("b2b_0");
    wait_done("b2b_1");
    wait_done("b2b_2");
    start = 1'b0;

    repeat (W + 4) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    chk("done_count", n_done, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
